// File: rtl/mem_pkg.sv
// Shared types and defaults for the on-chip memory responder.
// Word width, read-pipeline stage record and default geometry/latency.
package mem_pkg;

  localparam int WORD_W               = 16;
  localparam int DEFAULT_ADDR_W       = 10;
  localparam int DEFAULT_READ_LATENCY = 2;

  typedef logic [WORD_W-1:0] word_t;

  typedef struct packed {
    logic  valid;
    word_t data;
  } rd_stage_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU request/response and loader side-band bundle for mem_responder.
// The master drives requests; the slave (the memory) returns read data and status.
interface mem_responder_if;
  import mem_pkg::*;

  logic [15:0] mem_addr;
  logic        mem_ena;
  logic        wr_ena;
  word_t       wdata;
  word_t       rdata;
  logic        rdata_valid;
  logic        ld_ena;
  logic [15:0] ld_addr;
  word_t       ld_data;
  logic        busy;

  modport master (
    output mem_addr, mem_ena, wr_ena, wdata, ld_ena, ld_addr, ld_data,
    input  rdata, rdata_valid, busy
  );

  modport slave (
    input  mem_addr, mem_ena, wr_ena, wdata, ld_ena, ld_addr, ld_data,
    output rdata, rdata_valid, busy
  );

endinterface

// File: rtl/mem_array.sv
// Word RAM with a synchronous read port and the CPU/loader write pair.
// Same-address collisions are resolved upstream, so the two writes never overlap.
module mem_array
  import mem_pkg::*;
#(
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_waddr,
  input  word_t             cpu_wdata,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_waddr,
  input  word_t             ld_wdata,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] raddr,
  output word_t             rd_data
);

  localparam int DEPTH = 2 ** ADDR_W;

  word_t mem [DEPTH];
  word_t rd_data_reg;

  always_ff @(posedge clk) begin
    if (cpu_we) mem[cpu_waddr] <= cpu_wdata;
    if (ld_we)  mem[ld_waddr]  <= ld_wdata;
  end

  // Read returns the pre-edge contents, so a same-edge write is not visible.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data_reg <= mem[raddr];
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/mem_responder.sv
// On-chip memory acting as the CPU memory responder with fixed read latency.
// Stage 0 is the RAM's own read register; stages 1..READ_LATENCY-1 follow it.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W       = DEFAULT_ADDR_W,
  parameter int READ_LATENCY = DEFAULT_READ_LATENCY
) (
  input  logic             clk,
  input  logic             reset,
  mem_responder_if.slave   bus
);

  logic [ADDR_W-1:0] cpu_addr;
  logic [ADDR_W-1:0] ld_addr;
  logic              rd_issue;
  logic              cpu_wr;
  logic              cpu_wr_eff;
  word_t             ram_q;
  rd_stage_t         stage [READ_LATENCY];
  logic [READ_LATENCY-1:0] valid_vec;
  logic              valid0_reg;

  assign cpu_addr = bus.mem_addr[ADDR_W-1:0];
  assign ld_addr  = bus.ld_addr[ADDR_W-1:0];
  assign rd_issue = bus.mem_ena & ~bus.wr_ena;
  assign cpu_wr   = bus.mem_ena & bus.wr_ena;

  // Loader wins a same-address collision by suppressing the CPU write.
  assign cpu_wr_eff = cpu_wr & ~(bus.ld_ena && (ld_addr == cpu_addr));

  mem_array #(.ADDR_W(ADDR_W)) u_array (
    .clk       (clk),
    .cpu_we    (cpu_wr_eff),
    .cpu_waddr (cpu_addr),
    .cpu_wdata (bus.wdata),
    .ld_we     (bus.ld_ena),
    .ld_waddr  (ld_addr),
    .ld_wdata  (bus.ld_data),
    .rd_en     (rd_issue),
    .raddr     (cpu_addr),
    .rd_data   (ram_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) valid0_reg <= 1'b0;
    else       valid0_reg <= rd_issue;
  end

  generate
    for (genvar gi = 0; gi < READ_LATENCY; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign stage[gi] = '{valid: valid0_reg, data: ram_q};
      end else begin : g_tail
        rd_stage_t stage_reg;
        // Data only moves with a valid token so the last stage holds rdata.
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            stage_reg <= '0;
          end else begin
            stage_reg.valid <= stage[gi-1].valid;
            if (stage[gi-1].valid) stage_reg.data <= stage[gi-1].data;
          end
        end
        assign stage[gi] = stage_reg;
      end
      assign valid_vec[gi] = stage[gi].valid;
    end

    if (READ_LATENCY == 1) begin : g_out_direct
      // RAM register is not reset; mask it until the first post-reset completion.
      logic live_reg;
      always_ff @(posedge clk or posedge reset) begin
        if (reset)               live_reg <= 1'b0;
        else if (stage[0].valid) live_reg <= 1'b1;
      end
      assign bus.rdata = live_reg ? ram_q : '0;
    end else begin : g_out_piped
      assign bus.rdata = stage[READ_LATENCY-1].data;
    end
  endgenerate

  assign bus.rdata_valid = stage[READ_LATENCY-1].valid;
  assign bus.busy        = |valid_vec;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (ADDR_W=10, READ_LATENCY=2).
// Inputs change 1ns after a rising edge; outputs are sampled at that same point.
`timescale 1ns/1ps
module tb_mem_responder;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  mem_responder_if bus ();

  mem_responder #(.ADDR_W(10), .READ_LATENCY(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.mem_ena = 1'b0;
    bus.wr_ena  = 1'b0;
    bus.mem_addr = 16'h0000;
    bus.wdata   = 16'h0000;
    bus.ld_ena  = 1'b0;
    bus.ld_addr = 16'h0000;
    bus.ld_data = 16'h0000;
  endtask

  task automatic put_read(input logic [15:0] a);
    bus.mem_ena = 1'b1;
    bus.wr_ena  = 1'b0;
    bus.mem_addr = a;
  endtask

  task automatic put_write(input logic [15:0] a, input logic [15:0] d);
    bus.mem_ena = 1'b1;
    bus.wr_ena  = 1'b1;
    bus.mem_addr = a;
    bus.wdata   = d;
  endtask

  task automatic put_load(input logic [15:0] a, input logic [15:0] d);
    bus.ld_ena  = 1'b1;
    bus.ld_addr = a;
    bus.ld_data = d;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (3) step();
    n_cmp++; if (bus.rdata !== 16'h0000) begin n_fail++; $display("FAIL reset_rdata: got %h expected %h", bus.rdata, 16'h0000); end
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", bus.rdata_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
    step();
    $display("reset released");
  endtask

  task automatic test_load_read();
    idle(); put_load(16'h0005, 16'h1234); step();
    idle(); put_read(16'h0005); step();           // issue edge N
    idle();
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lr_busy_n1: got %b expected 1", bus.busy); end
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL lr_valid_n1: got %b expected 0", bus.rdata_valid); end
    step();                                        // cycle N+2
    n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL lr_valid_n2: got %b expected 1", bus.rdata_valid); end
    n_cmp++; if (bus.rdata !== 16'h1234) begin n_fail++; $display("FAIL lr_data: got %h expected %h", bus.rdata, 16'h1234); end
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL lr_busy_n2: got %b expected 1", bus.busy); end
    $display("read 0005 -> %h", bus.rdata);
    step();
    n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL lr_valid_n3: got %b expected 0", bus.rdata_valid); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL lr_busy_n3: got %b expected 0", bus.busy); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_d;
    for (int i = 0; i < 4; i++) begin
      idle(); put_load(16'(i), 16'hA000 + 16'(i)); step();
    end
    for (int c = 0; c < 7; c++) begin
      idle();
      if (c < 4) put_read(16'(c));
      step();
      if (c >= 1 && c <= 4) begin
        exp_d = 16'hA000 + 16'(c - 1);
        n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid[%0d]: got %b expected 1", c, bus.rdata_valid); end
        n_cmp++; if (bus.rdata !== exp_d) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h expected %h", c, bus.rdata, exp_d); end
        $display("b2b completion %0d -> %h", c - 1, bus.rdata);
      end else begin
        n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle[%0d]: got %b expected 0", c, bus.rdata_valid); end
      end
    end
  endtask

  task automatic test_read_during_write();
    idle(); put_load(16'h0001, 16'h0011); step();
    idle(); put_read(16'h0001); step();
    idle(); put_write(16'h0001, 16'hBEEF); step();
    idle();
    n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL rdw_valid: got %b expected 1", bus.rdata_valid); end
    n_cmp++; if (bus.rdata !== 16'h0011) begin n_fail++; $display("FAIL rdw_old: got %h expected %h", bus.rdata, 16'h0011); end
    $display("read-during-write -> %h", bus.rdata);
    step();
    put_read(16'h0001); step();
    idle(); step();
    n_cmp++; if (bus.rdata !== 16'hBEEF) begin n_fail++; $display("FAIL rdw_new: got %h expected %h", bus.rdata, 16'hBEEF); end
    $display("read after write -> %h", bus.rdata);
  endtask

  task automatic test_collision();
    idle(); put_write(16'h0010, 16'h1111); put_load(16'h0010, 16'h2222); step();
    idle(); put_write(16'h0020, 16'h3333); put_load(16'h0021, 16'h4444); step();
    idle(); put_read(16'h0010); step();
    idle(); put_read(16'h0020); step();
    idle(); put_read(16'h0021);
    n_cmp++; if (bus.rdata !== 16'h2222) begin n_fail++; $display("FAIL coll_same: got %h expected %h", bus.rdata, 16'h2222); end
    step();
    idle();
    n_cmp++; if (bus.rdata !== 16'h3333) begin n_fail++; $display("FAIL coll_cpu: got %h expected %h", bus.rdata, 16'h3333); end
    step();
    n_cmp++; if (bus.rdata !== 16'h4444) begin n_fail++; $display("FAIL coll_ld: got %h expected %h", bus.rdata, 16'h4444); end
    $display("collision reads done, last -> %h", bus.rdata);
  endtask

  task automatic test_read_vs_loader();
    idle(); put_load(16'h0030, 16'hAAAA); step();
    idle(); put_read(16'h0030); put_load(16'h0030, 16'hBBBB); step();
    idle(); step();
    n_cmp++; if (bus.rdata !== 16'hAAAA) begin n_fail++; $display("FAIL rvl_old: got %h expected %h", bus.rdata, 16'hAAAA); end
    put_read(16'h0030); step();
    idle(); step();
    n_cmp++; if (bus.rdata !== 16'hBBBB) begin n_fail++; $display("FAIL rvl_new: got %h expected %h", bus.rdata, 16'hBBBB); end
    $display("read vs loader -> %h", bus.rdata);
  endtask

  task automatic test_reset_flush();
    idle(); put_load(16'h0040, 16'h7777); step();
    idle(); put_read(16'h0040); step();
    idle();
    reset = 1'b1;
    #1;
    n_cmp++; if (bus.rdata !== 16'h0000) begin n_fail++; $display("FAIL rf_rdata: got %h expected %h", bus.rdata, 16'h0000); end
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rf_busy: got %b expected 0", bus.busy); end
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL rf_no_pulse[%0d]: got %b expected 0", i, bus.rdata_valid); end
    end
    put_read(16'h0040); step();
    idle(); step();
    n_cmp++; if (bus.rdata !== 16'h7777) begin n_fail++; $display("FAIL rf_retained: got %h expected %h", bus.rdata, 16'h7777); end
    $display("after reset read 0040 -> %h", bus.rdata);
  endtask

  task automatic test_alias();
    idle(); put_write(16'h0403, 16'h5A5A); step();
    idle(); put_read(16'h0003); step();
    idle(); step();
    n_cmp++; if (bus.rdata_valid !== 1'b1) begin n_fail++; $display("FAIL alias_valid: got %b expected 1", bus.rdata_valid); end
    n_cmp++; if (bus.rdata !== 16'h5A5A) begin n_fail++; $display("FAIL alias_data: got %h expected %h", bus.rdata, 16'h5A5A); end
    $display("alias read 0003 -> %h", bus.rdata);
    for (int i = 0; i < 10; i++) begin
      step();
      n_cmp++; if (bus.rdata_valid !== 1'b0) begin n_fail++; $display("FAIL hold_valid[%0d]: got %b expected 0", i, bus.rdata_valid); end
      n_cmp++; if (bus.rdata !== 16'h5A5A) begin n_fail++; $display("FAIL hold_data[%0d]: got %h expected %h", i, bus.rdata, 16'h5A5A); end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_load_read();
    test_back_to_back();
    test_read_during_write();
    test_collision();
    test_read_vs_loader();
    test_reset_flush();
    test_alias();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
